// File: rtl/song_block_writer.sv
// Write side of the song note memory: packs a valid/ready note stream into blocks of
// 1..MAX_BLOCK notes, writing each note and one (start, size) table entry per block.
`timescale 1ns/1ps
module song_block_writer #(
  parameter int NOTE_DEPTH  = 512,
  parameter int BLOCK_DEPTH = 512,
  parameter int MAX_BLOCK   = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        flush_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [15:0] in_note_i,
  input  logic        in_last_i,
  output logic        mem_we_o,
  output logic [8:0]  mem_addr_o,
  output logic [15:0] mem_wdata_o,
  output logic        blk_we_o,
  output logic [8:0]  blk_idx_o,
  output logic [8:0]  blk_start_o,
  output logic [2:0]  blk_size_o,
  output logic [9:0]  blocks_written_o,
  output logic [9:0]  notes_written_o,
  output logic        full_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_COMMIT, ST_FULL} state_t;

  localparam logic [9:0] NOTE_LIMIT  = 10'(NOTE_DEPTH);
  localparam logic [9:0] BLOCK_LIMIT = 10'(BLOCK_DEPTH);
  localparam logic [9:0] LAST_ADDR   = 10'(NOTE_DEPTH - 1);
  localparam logic [2:0] MAX_PEND    = 3'(MAX_BLOCK);

  state_t      state_q, state_d;
  logic        in_ready_q, full_q, busy_q;
  logic        mem_we_q, blk_we_q;
  logic [8:0]  mem_addr_q, blk_idx_q, blk_start_q, blk_base_q;
  logic [15:0] mem_wdata_q;
  logic [2:0]  blk_size_q, pending_q, pending_d;
  logic [9:0]  notes_written_q, blocks_written_q;
  logic        accept, close_blk, commit_to_full;

  // The note address is the running note count: blocks never leave gaps.
  always_comb begin
    accept         = in_valid_i & in_ready_q & ~start_i;
    pending_d      = pending_q + {2'b00, accept};
    close_blk      = (accept & (in_last_i | (pending_d == MAX_PEND) |
                                (notes_written_q == LAST_ADDR)))
                   | (in_ready_q & flush_i & ~start_i & (pending_d != 3'd0));
    commit_to_full = (notes_written_q == NOTE_LIMIT) |
                     ((blocks_written_q + 10'd1) == BLOCK_LIMIT);
    state_d = state_q;
    if (start_i) begin
      state_d = ST_FILL;
    end else begin
      case (state_q)
        ST_FILL:   if (close_blk) state_d = ST_COMMIT;
        ST_COMMIT: state_d = commit_to_full ? ST_FULL : ST_FILL;
        default:   state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q          <= ST_IDLE;
      in_ready_q       <= 1'b0;
      full_q           <= 1'b0;
      busy_q           <= 1'b0;
      mem_we_q         <= 1'b0;
      mem_addr_q       <= '0;
      mem_wdata_q      <= '0;
      blk_we_q         <= 1'b0;
      blk_idx_q        <= '0;
      blk_start_q      <= '0;
      blk_size_q       <= '0;
      blk_base_q       <= '0;
      pending_q        <= '0;
      notes_written_q  <= '0;
      blocks_written_q <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d == ST_FILL);
      full_q     <= (state_d == ST_FULL);
      busy_q     <= (state_d != ST_IDLE);
      mem_we_q   <= 1'b0;
      blk_we_q   <= 1'b0;
      if (start_i) begin
        // A pending partial block is dropped without a table entry.
        pending_q        <= '0;
        blk_base_q       <= '0;
        notes_written_q  <= '0;
        blocks_written_q <= '0;
      end else if (accept) begin
        mem_we_q        <= 1'b1;
        mem_addr_q      <= notes_written_q[8:0];
        mem_wdata_q     <= in_note_i;
        notes_written_q <= notes_written_q + 10'd1;
        pending_q       <= pending_d;
      end else if (state_q == ST_COMMIT) begin
        blk_we_q         <= 1'b1;
        blk_idx_q        <= blocks_written_q[8:0];
        blk_start_q      <= blk_base_q;
        blk_size_q       <= pending_q;
        blocks_written_q <= blocks_written_q + 10'd1;
        blk_base_q       <= notes_written_q[8:0];
        pending_q        <= '0;
      end
    end
  end

  assign in_ready_o       = in_ready_q;
  assign full_o           = full_q;
  assign busy_o           = busy_q;
  assign mem_we_o         = mem_we_q;
  assign mem_addr_o       = mem_addr_q;
  assign mem_wdata_o      = mem_wdata_q;
  assign blk_we_o         = blk_we_q;
  assign blk_idx_o        = blk_idx_q;
  assign blk_start_o      = blk_start_q;
  assign blk_size_o       = blk_size_q;
  assign blocks_written_o = blocks_written_q;
  assign notes_written_o  = notes_written_q;

endmodule
